// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key-code table for the 4x4 keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  // indexed {row, col}
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    KEY_STAR, 4'h0, KEY_HASH, 4'hD
  };
  function automatic logic [1:0] low_row(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/module_sync2.sv
// module_sync2: 2-flop synchronizer for asynchronous inputs
//   clk, rst : clock, sync active-high reset (flops load init)
//   d        : asynchronous input
//   q        : synchronized output, 2 cycles behind d
module module_sync2 #(
  parameter int width = 1,
  parameter logic [width-1:0] init = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [width-1:0] m;
  always_ff @(posedge clk) begin
    m <= rst ? init : d;
    q <= rst ? init : m;
  end
endmodule

// File: rtl/module_keypad_scanner.sv
// module_keypad_scanner: 4x4 matrix keypad scanner with debounce
//   clk, rst  : clock, sync active-high reset
//   row       : active-low rows, asynchronous
//   col       : active-low one-hot column drive
//   key_code  : last accepted key, held until next accept
//   key_valid : one-cycle strobe coincident with key_code update
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int frequency = 27_000_000,
  parameter int max_count = frequency / 1000,
  parameter int deb_count = frequency / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int DW = $clog2(max_count);
  localparam int BW = $clog2(deb_count);
  localparam logic [DW-1:0] DL = DW'(max_count - 1);
  // compare one below terminal: the counter reaches deb_count-1 on the same edge the action is registered
  localparam logic [BW-1:0] BL = BW'(deb_count - 2);
  kp_state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [1:0] c_idx, c_n, r_idx, r_n;
  logic [3:0] row_s, code_n;
  logic valid_n, hit;
  module_sync2 #(.width(4), .init(4'hF)) u_sync (.clk(clk), .rst(rst), .d(row), .q(row_s));
  assign col = ~(4'b0001 << c_idx);
  assign hit = ~row_s[r_idx];
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    bcnt_n = bcnt;
    c_n = c_idx;
    r_n = r_idx;
    code_n = key_code;
    valid_n = 1'b0;
    case (state)
      SCAN:
        if (dcnt == DL) begin
          dcnt_n = '0;
          if (row_s != 4'hF) begin
            state_n = DEBOUNCE;
            bcnt_n = '0;
            r_n = low_row(row_s);
          end else c_n = c_idx + 2'd1;
        end else dcnt_n = dcnt + 1'b1;
      DEBOUNCE:
        if (!hit) begin
          state_n = SCAN;
          c_n = c_idx + 2'd1;
          dcnt_n = '0;
        end else if (bcnt == BL) begin
          state_n = HELD;
          bcnt_n = '0;
          valid_n = 1'b1;
          code_n = KEY_MAP[{r_idx, c_idx}];
        end else bcnt_n = bcnt + 1'b1;
      HELD:
        if (hit) bcnt_n = '0;
        else if (bcnt == BL) begin
          state_n = SCAN;
          c_n = c_idx + 2'd1;
          dcnt_n = '0;
        end else bcnt_n = bcnt + 1'b1;
      default: state_n = SCAN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      dcnt <= '0;
      bcnt <= '0;
      c_idx <= 2'd0;
      r_idx <= 2'd0;
      key_code <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
      bcnt <= bcnt_n;
      c_idx <= c_n;
      r_idx <= r_n;
      key_code <= code_n;
      key_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb_module_keypad_scanner: scoreboard bench with a keypad matrix model
module tb_module_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid;
  logic [15:0] keys = '0;
  logic [3:0] exp_q [$];
  logic prev_v = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  module_keypad_scanner #(.frequency(400), .max_count(4), .deb_count(8)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code), .key_valid(key_valid)
  );
  always #5 clk = ~clk;
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end
  task automatic check(input string n, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", n, got, exp);
  endtask
  task automatic wait_col(input logic [3:0] t, input string n);
    int k = 0;
    while (col !== t && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(n, {4'h0, col}, {4'h0, t});
  endtask
  task automatic wait_leave(input logic [3:0] from, input logic [3:0] t, input string n);
    int k = 0;
    while (col === from && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(n, {4'h0, col}, {4'h0, t});
  endtask
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse got=%h exp=none", key_code);
      end else check("key_code", {4'h0, key_code}, {4'h0, exp_q.pop_front()});
      check("no_double_pulse", {7'h0, prev_v}, 8'h0);
    end
    prev_v = key_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    logic bad;
    repeat (3) @(negedge clk);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_code", {4'h0, key_code}, 8'h00);
    check("rst_valid", {7'h0, key_valid}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_col", {4'h0, col}, {4'h0, ~(4'b0001 << ((i / 4) % 4))});
      @(negedge clk);
    end
    keys[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_col(4'b1101, "seek_c1_5");
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (col !== 4'b1101) bad = 1'b1;
    end
    check("held_col_5", {7'h0, bad}, 8'h0);
    keys[5] = 1'b0;
    repeat (8) @(negedge clk);
    check("release_hold_5", {4'h0, col}, 8'h0D);
    @(negedge clk);
    check("resume_5", {4'h0, col}, 8'h0B);
    keys[10] = 1'b1;
    repeat (3) @(negedge clk);
    keys[10] = 1'b0;
    wait_leave(4'b1011, 4'b0111, "bounce_9_next");
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    exp_q.push_back(4'h2);
    wait_col(4'b1101, "seek_c1_28");
    repeat (16) @(negedge clk);
    keys[1] = 1'b0;
    exp_q.push_back(4'h8);
    repeat (8) @(negedge clk);
    check("release_hold_2", {4'h0, col}, 8'h0D);
    @(negedge clk);
    check("resume_2", {4'h0, col}, 8'h0B);
    repeat (40) @(negedge clk);
    keys[9] = 1'b0;
    wait_leave(4'b1101, 4'b1011, "resume_8");
    keys[12] = 1'b1;
    exp_q.push_back(4'hE);
    repeat (40) @(negedge clk);
    keys[12] = 1'b0;
    repeat (20) @(negedge clk);
    keys[14] = 1'b1;
    exp_q.push_back(4'hF);
    repeat (40) @(negedge clk);
    keys[14] = 1'b0;
    repeat (20) @(negedge clk);
    wait_col(4'b1011, "seek_c2_A");
    keys[3] = 1'b1;
    wait_col(4'b0111, "seek_c3_A");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_col", {4'h0, col}, 8'h0E);
    check("midrst_code", {4'h0, key_code}, 8'h00);
    check("midrst_valid", {7'h0, key_valid}, 8'h00);
    keys[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
